// File: rtl/training_requester.sv
// Requester front-end for the round-robin/strict-priority arbiter: pending counters, grant checking, starvation restart.
// Latency: req is registered (push in cycle t visible in t+1); arb, gnt_valid, gnt_idx are combinational on grant.
// Backpressure: arb only asserts when ready=1 and no restart is in progress; saturated pushes are dropped with a drop pulse.
module training_requester #(
  parameter int W          = 8,
  parameter int CW         = 4,
  parameter int SW         = 6,
  parameter int STARVE_LIM = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [W-1:0]         i_push,
  input  logic                 i_ready,
  input  logic [W-1:0]         i_grant,
  output logic [W-1:0]         o_req,
  output logic                 o_arb,
  output logic                 o_restart,
  output logic [W-1:0]         o_restart_vec,
  output logic                 o_gnt_valid,
  output logic [$clog2(W)-1:0] o_gnt_idx,
  output logic [W-1:0]         o_drop,
  output logic                 o_err_onehot,
  output logic                 o_err_spurious
);

  localparam int IW = $clog2(W);
  localparam logic [CW-1:0] PEND_MAX = '1;
  localparam logic [SW-1:0] WAIT_LIM = SW'(STARVE_LIM);

  typedef enum logic [1:0] {S_IDLE, S_RESTART, S_WAIT_GNT} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [IW-1:0]   r_target;
  logic [CW-1:0]   r_pend [W];
  logic [SW-1:0]   r_wait [W];
  logic [W-1:0]    r_drop;
  logic            r_err_onehot;
  logic            r_err_spurious;

  logic [W-1:0]    w_req;
  logic            w_arb;
  logic            w_onehot;
  logic            w_legal;
  logic [W-1:0]    w_acc;
  logic [IW-1:0]   w_idx;
  logic [W-1:0]    w_starve;
  logic [IW-1:0]   w_first;
  logic [IW-1:0]   w_prev;
  logic            w_restart;
  logic [W-1:0]    w_restart_vec;
  logic            w_arb_block;

  // Request flags and starvation flags decoded from the per-port counters
  always_comb begin
    w_req    = '0;
    w_starve = '0;
    for (int i = 0; i < W; i++) begin
      w_req[i]    = (r_pend[i] != '0);
      w_starve[i] = (r_wait[i] == WAIT_LIM);
    end
  end

  // Lowest-index starving port becomes the restart target
  always_comb begin
    w_first = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (w_starve[i]) w_first = IW'(i);
    end
  end

  // Grant legality: one-hot and aimed at a port that is actually requesting
  always_comb begin
    w_arb    = i_ready & (|w_req) & ~w_arb_block;
    w_onehot = (i_grant != '0) && ((i_grant & (i_grant - W'(1))) == '0);
    w_legal  = w_arb & w_onehot & (|(i_grant & w_req));
    w_acc    = w_legal ? i_grant : '0;
  end

  // Binary index of the accepted grant (0 when nothing accepted)
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (w_acc[i]) w_idx = IW'(i);
    end
  end

  // Pending counters with saturation; push and accept on the same port cancel
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < W; i++) r_pend[i] <= '0;
      r_drop <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        r_drop[i] <= i_push[i] & ~w_acc[i] & (r_pend[i] == PEND_MAX);
        if (i_push[i] && !w_acc[i] && (r_pend[i] != PEND_MAX)) begin
          r_pend[i] <= r_pend[i] + 1'b1;
        end else if (!i_push[i] && w_acc[i]) begin
          r_pend[i] <= r_pend[i] - 1'b1;
        end
      end
    end
  end

  // Wait counters: count cycles a port requests without being served, saturating at the limit
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < W; i++) r_wait[i] <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (!w_req[i] || w_acc[i]) begin
          r_wait[i] <= '0;
        end else if (r_wait[i] != WAIT_LIM) begin
          r_wait[i] <= r_wait[i] + 1'b1;
        end
      end
    end
  end

  // Sticky protocol error flags
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_err_onehot   <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      r_err_onehot   <= r_err_onehot | (w_arb & ~w_onehot);
      r_err_spurious <= r_err_spurious | (w_arb & w_onehot & ~(|(i_grant & w_req)));
    end
  end

  // Restart target is captured on the IDLE->RESTART transition
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_target <= '0;
    end else if ((r_state == S_IDLE) && (|w_starve)) begin
      r_target <= w_first;
    end
  end

  // Starvation FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next_state;
  end

  // Starvation FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (|w_starve) w_next_state = S_RESTART;
      S_RESTART:  w_next_state = S_WAIT_GNT;
      S_WAIT_GNT: if (w_acc[r_target] || !w_req[r_target]) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Starvation FSM outputs: restart pulse points the arbiter's last winner at target-1
  always_comb begin
    w_prev        = (r_target == '0) ? IW'(W - 1) : (r_target - 1'b1);
    w_restart     = 1'b0;
    w_restart_vec = '0;
    w_arb_block   = 1'b0;
    if (r_state == S_RESTART) begin
      w_restart     = 1'b1;
      w_restart_vec = W'(1) << w_prev;
      w_arb_block   = 1'b1;
    end
  end

  assign o_req          = w_req;
  assign o_arb          = w_arb;
  assign o_restart      = w_restart;
  assign o_restart_vec  = w_restart_vec;
  assign o_gnt_valid    = w_legal;
  assign o_gnt_idx      = w_idx;
  assign o_drop         = r_drop;
  assign o_err_onehot   = r_err_onehot;
  assign o_err_spurious = r_err_spurious;

endmodule

// File: tb/tb_training_requester.sv
module tb_training_requester;

  logic       clk;
  logic       rst_n;
  logic [7:0] push;
  logic       ready;
  logic [7:0] grant;
  logic [7:0] o_req;
  logic       o_arb;
  logic       o_restart;
  logic [7:0] o_restart_vec;
  logic       o_gnt_valid;
  logic [2:0] o_gnt_idx;
  logic [7:0] o_drop;
  logic       o_err_onehot;
  logic       o_err_spurious;

  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];

  training_requester #(.W(8), .CW(4), .SW(6), .STARVE_LIM(32)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_push         (push),
    .i_ready        (ready),
    .i_grant        (grant),
    .o_req          (o_req),
    .o_arb          (o_arb),
    .o_restart      (o_restart),
    .o_restart_vec  (o_restart_vec),
    .o_gnt_valid    (o_gnt_valid),
    .o_gnt_idx      (o_gnt_idx),
    .o_drop         (o_drop),
    .o_err_onehot   (o_err_onehot),
    .o_err_spurious (o_err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, sample 1ns later, scoreboard the grant.
  task automatic cyc(input logic [7:0] p, input logic r, input logic [7:0] g, input logic eg);
    int e;
    @(negedge clk);
    push  = p;
    ready = r;
    grant = g;
    #1;
    if (eg) begin
      e = 0;
      for (int i = 0; i < 8; i++) if (g[i]) e = i;
      exp_q.push_back(e);
    end
    chk("gnt_valid", {31'd0, o_gnt_valid}, {31'd0, eg});
    if (o_gnt_valid === 1'b1) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("gnt_idx", {29'd0, o_gnt_idx}, e);
    end else begin
      chk("gnt_idx_idle", {29'd0, o_gnt_idx}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    push  = '0;
    ready = 1'b0;
    grant = '0;

    // Reset state
    cyc(8'h00, 1'b1, 8'h00, 1'b0);
    cyc(8'h00, 1'b1, 8'h00, 1'b0);
    chk("rst_req", o_req, 0);
    chk("rst_arb", o_arb, 0);
    chk("rst_restart", o_restart, 0);
    chk("rst_rvec", o_restart_vec, 0);
    chk("rst_drop", o_drop, 0);
    chk("rst_err1h", o_err_onehot, 0);
    chk("rst_errsp", o_err_spurious, 0);
    rst_n = 1'b1;

    // Basic push and grant
    cyc(8'h05, 1'b1, 8'h00, 1'b0);
    chk("t1_arb_before", o_arb, 0);
    cyc(8'h00, 1'b1, 8'h01, 1'b1);
    chk("t1_req", o_req, 8'h05);
    chk("t1_arb", o_arb, 1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0);
    chk("t1_req_after", o_req, 8'h04);
    cyc(8'h00, 1'b1, 8'h04, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0);
    chk("t1_req_empty", o_req, 8'h00);

    // Saturation on port 3
    for (int i = 0; i < 16; i++) begin
      cyc(8'h08, 1'b0, 8'h00, 1'b0);
      chk("t2_no_drop", o_drop, 8'h00);
    end
    cyc(8'h00, 1'b0, 8'h00, 1'b0);
    chk("t2_drop", o_drop, 8'h08);
    cyc(8'h08, 1'b1, 8'h08, 1'b1);
    chk("t2_drop_clr", o_drop, 8'h00);
    cyc(8'h00, 1'b0, 8'h00, 1'b0);
    chk("t2_no_drop_sat_acc", o_drop, 8'h00);
    for (int i = 0; i < 15; i++) cyc(8'h00, 1'b1, 8'h08, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0);
    chk("t2_drained", o_req, 8'h00);

    // Error detection
    cyc(8'h03, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 8'h06, 1'b0);
    cyc(8'h00, 1'b1, 8'h06, 1'b0);
    chk("t3_no_err_arb0", o_err_onehot, 0);
    cyc(8'h00, 1'b0, 8'h00, 1'b0);
    chk("t3_err1h", o_err_onehot, 1);
    chk("t3_errsp_clear", o_err_spurious, 0);
    cyc(8'h00, 1'b1, 8'h80, 1'b0);
    cyc(8'h00, 1'b0, 8'h00, 1'b0);
    chk("t3_errsp", o_err_spurious, 1);
    chk("t3_err1h_sticky", o_err_onehot, 1);
    chk("t3_req_kept", o_req, 8'h03);
    cyc(8'h00, 1'b1, 8'h01, 1'b1);
    cyc(8'h00, 1'b1, 8'h02, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0);
    chk("t3_req_empty", o_req, 8'h00);

    // Starvation of port 0 while port 5 keeps winning
    cyc(8'h21, 1'b0, 8'h00, 1'b0);
    for (int j = 0; j < 33; j++) begin
      cyc(8'h20, 1'b1, 8'h20, 1'b1);
      chk("t4_no_restart", o_restart, 0);
    end
    cyc(8'h00, 1'b1, 8'h20, 1'b0);
    chk("t4_restart", o_restart, 1);
    chk("t4_rvec", o_restart_vec, 8'h80);
    chk("t4_arb_low", o_arb, 0);
    for (int j = 0; j < 4; j++) begin
      cyc(8'h20, 1'b1, 8'h20, 1'b1);
      chk("t4_wait_restart", o_restart, 0);
      chk("t4_wait_rvec", o_restart_vec, 8'h00);
    end
    cyc(8'h00, 1'b1, 8'h01, 1'b1);
    cyc(8'h00, 1'b1, 8'h20, 1'b1);
    for (int j = 0; j < 3; j++) begin
      cyc(8'h00, 1'b0, 8'h00, 1'b0);
      chk("t4_idle_restart", o_restart, 0);
    end
    chk("t4_req_empty", o_req, 8'h00);

    // Ports 2 and 6 starve together
    cyc(8'h44, 1'b0, 8'h00, 1'b0);
    for (int j = 0; j < 33; j++) begin
      cyc(8'h00, 1'b0, 8'h00, 1'b0);
      chk("t5_no_restart", o_restart, 0);
    end
    cyc(8'h00, 1'b0, 8'h00, 1'b0);
    chk("t5_restart", o_restart, 1);
    chk("t5_rvec", o_restart_vec, 8'h02);
    for (int j = 0; j < 3; j++) begin
      cyc(8'h00, 1'b0, 8'h00, 1'b0);
      chk("t5_wait_restart", o_restart, 0);
    end
    cyc(8'h00, 1'b1, 8'h04, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0);
    chk("t5_idle_restart", o_restart, 0);
    cyc(8'h00, 1'b0, 8'h00, 1'b0);
    chk("t5_restart6", o_restart, 1);
    chk("t5_rvec6", o_restart_vec, 8'h20);
    chk("t5_err1h_pre", o_err_onehot, 1);
    chk("t5_errsp_pre", o_err_spurious, 1);

    // Reset during RESTART
    rst_n = 1'b0;
    cyc(8'h00, 1'b1, 8'h00, 1'b0);
    chk("t6_restart", o_restart, 0);
    chk("t6_rvec", o_restart_vec, 8'h00);
    chk("t6_req", o_req, 8'h00);
    chk("t6_arb", o_arb, 0);
    chk("t6_err1h", o_err_onehot, 0);
    chk("t6_errsp", o_err_spurious, 0);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cyc(8'h00, 1'b1, 8'h00, 1'b0);
      chk("t6_post_restart", o_restart, 0);
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
